mcif_rsp_router4: RTL and testbench
===================================

Name: mcif_rsp_router4

Overview:
Return-path counterpart of the 4-client MCIF round-robin request arbiter. It records the client ID of every read request accepted downstream in an in-order ID FIFO. It then demultiplexes returning read-data bursts from the single memory response channel back to the originating client. It sits between the MCIF memory-side read-return port and the four client read-data ports.

Parameters:
DATA_W, 256, width of the response data beat.
DEPTH, 16, maximum number of outstanding read requests; power of two, at least 2.
CNT_W, 5, width of the outstanding counter; equals log2(DEPTH)+1.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
req_accept  input  1  pulse: a request handshake (gnt_valid&gnt_ready) completed this cycle.
req_is_read  input  1  qualifies req_accept; only reads are tracked.
req_client_id  input  2  client index granted for the accepted request.
req_allow  output  1  ID FIFO can take another read; feeds the arbiter's gnt_valid gating.
rsp_valid  input  1  memory response beat valid.
rsp_data  input  DATA_W  response beat.
rsp_last  input  1  final beat of the burst.
rsp_ready  output  1  response beat consumed.
clt_rsp_valid  output  4  one-hot per-client beat valid.
clt_rsp_data  output  DATA_W  shared data bus to all clients.
clt_rsp_last  output  1  shared last flag.
clt_rsp_ready  input  4  per-client ready.
outstanding  output  CNT_W  number of read bursts not yet fully returned.
err_unexpected  output  1  sticky: a response beat arrived with no outstanding request.
err_overflow  output  1  sticky: a push was attempted while the FIFO was full.

Behaviour:
- Reset: FIFO pointers, outstanding and both error flags go to 0. req_allow=1. rsp_ready=0. clt_rsp_valid=0.
- Push: push = req_accept & req_is_read & ~full. The ID is written at the write pointer and the pointer advances modulo DEPTH.
- Full push: req_accept & req_is_read while full does not push and sets err_overflow. A pop in the same cycle does not rescue the push.
- req_allow = ~full. It is combinational from registered count only, with no path from req_accept.
- Head: head_id is the FIFO entry at the read pointer. It is valid when ~empty.
- Routing, FIFO not empty:
  - clt_rsp_valid[i] = rsp_valid & (head_id==i).
  - rsp_ready = clt_rsp_ready[head_id].
  - clt_rsp_data = rsp_data and clt_rsp_last = rsp_last, unconditionally.
  - Latency is 0 cycles (combinational pass-through).
- Pop: pop = rsp_valid & rsp_ready & rsp_last & ~empty. Non-last beats never pop, so multi-beat bursts stay locked to one client.
- Empty FIFO with rsp_valid=1: rsp_ready=1 and the beat is dropped. err_unexpected sets. clt_rsp_valid stays 0.
- Simultaneous push and pop: both pointers move and outstanding is unchanged. Valid at any non-full occupancy, including empty → push only, since pop requires ~empty.
- outstanding: +1 on push, −1 on pop. It never exceeds DEPTH and never goes below 0.
- Pointers are AW+1 bits wide, with AW=log2(DEPTH). full = MSBs differ and lower bits equal; empty = pointers equal.
- Error flags clear only on reset.
- Asynchronous reset mid-burst: all state clears and in-flight IDs are lost. The system resets the memory side concurrently.

Optional Feature:
MCIF_RSP_OUT_REG_EN.
- Defined: a 2-entry skid buffer sits on the client side. It registers clt_rsp_valid/data/last, and rsp_ready becomes a registered signal meaning "skid not full".
  - Latency is 1 cycle; throughput is 1 beat/cycle.
  - Pop occurs when the last beat enters the skid, not when the client takes it.
  - Reset empties the skid.
- Undefined: combinational path as described in Behaviour.

Decomposition:
- Package mcif_rsp_pkg: NUM_CLT=4, CLT_ID_W=2, and an encoding function for the one-hot client valid.
- Sub-module mcif_id_fifo: parameterised DEPTH×CLT_ID_W synchronous FIFO with push/pop/full/empty/count and async reset. The router instantiates it once, plus the optional skid.

Test Plan:
- Accept reads for clients 2,0,3. Return bursts of 4,1,2 beats with all clt_rsp_ready=1 → beats appear only on clt_rsp_valid[2], then [0], then [3]; outstanding steps 3→2→1→0 on each last beat.
- Head = client 1 with clt_rsp_ready[1]=0 for 5 cycles and clt_rsp_ready[0]=1 → rsp_ready=0 and the beat is held; no other client sees valid; the beat is delivered once ready[1]=1.
- Push 16 reads → req_allow=0 and outstanding=16. A 17th req_accept sets err_overflow with count still 16. One full burst return → req_allow=1.
- rsp_valid=1 with FIFO empty → rsp_ready=1, clt_rsp_valid=0, err_unexpected=1 and stays set; a later normal request/response routes correctly.
- Push client 3 and pop the last beat of client 1 in the same cycle with count=5 → count stays 5; the next head is the entry after client 1.
- With MCIF_RSP_OUT_REG_EN, a back-to-back 8-beat burst with ready toggling 1010... → all 8 beats delivered in order, none lost or duplicated, first beat 1 cycle after rsp_valid; rst_n pulsed mid-burst → all outputs 0 next edge.

Source files
------------

// File: rtl/mcif_rsp_pkg.sv
// rtl/mcif_rsp_pkg.sv - shared client constants and one-hot valid encoder for the MCIF response router
package mcif_rsp_pkg;

    localparam int NUM_CLT  = 4;
    localparam int CLT_ID_W = 2;

    function automatic logic [NUM_CLT-1:0] clt_onehot(input logic [CLT_ID_W-1:0] id, input logic en);
        clt_onehot     = '0;
        clt_onehot[id] = en;
    endfunction

endpackage

// File: rtl/mcif_id_fifo.sv
// rtl/mcif_id_fifo.sv - in-order client ID FIFO with extra-MSB pointers and async active-low reset
module mcif_id_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = CNT_W'(wptr_q - rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read while the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mcif_rsp_router4.sv
// rtl/mcif_rsp_router4.sv - routes read-return bursts to 4 clients by in-order ID; MCIF_RSP_OUT_REG_EN adds client-side skid
module mcif_rsp_router4
    import mcif_rsp_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_accept,
    input  logic               req_is_read,
    input  logic [1:0]         req_client_id,
    output logic               req_allow,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_data,
    input  logic               rsp_last,
    output logic               rsp_ready,
    output logic [3:0]         clt_rsp_valid,
    output logic [DATA_W-1:0]  clt_rsp_data,
    output logic               clt_rsp_last,
    input  logic [3:0]         clt_rsp_ready,
    output logic [CNT_W-1:0]   outstanding,
    output logic               err_unexpected,
    output logic               err_overflow
);

    logic                push, pop, full, empty;
    logic [CLT_ID_W-1:0] head_id;
    logic                err_unexp_q, err_unexp_d;
    logic                err_ovf_q, err_ovf_d;

    assign push      = req_accept & req_is_read & ~full;
    assign pop       = rsp_valid & rsp_ready & rsp_last & ~empty;
    assign req_allow = ~full;

    mcif_id_fifo #(
        .DEPTH (DEPTH),
        .W     (CLT_ID_W),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (req_client_id),
        .pop_i   (pop),
        .dout_o  (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );

`ifdef MCIF_RSP_OUT_REG_EN
    typedef struct packed {
        logic [CLT_ID_W-1:0] id;
        logic                last;
        logic [DATA_W-1:0]   data;
    } skid_t;

    skid_t      e0_q, e0_d, e1_q, e1_d, beat_in;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q;
    logic       enq, deq;

    assign rsp_ready     = rdy_q;
    assign clt_rsp_valid = clt_onehot(e0_q.id, cnt_q != 2'd0);
    assign clt_rsp_data  = e0_q.data;
    assign clt_rsp_last  = e0_q.last;

    // Beats with no outstanding ID are swallowed upstream and never enter the skid.
    assign enq     = rsp_valid & rdy_q & ~empty;
    assign deq     = (cnt_q != 2'd0) & clt_rsp_ready[e0_q.id];
    assign beat_in = '{id: head_id, last: rsp_last, data: rsp_data};

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({enq, deq})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = beat_in;
                else               e1_d = beat_in;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = beat_in;
                end else begin
                    e0_d = e1_q;
                    e1_d = beat_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
        end
    end
`else
    // Empty FIFO: accept and drop any beat so a stray response cannot wedge the memory port.
    assign rsp_ready     = empty ? rsp_valid : clt_rsp_ready[head_id];
    assign clt_rsp_valid = clt_onehot(head_id, rsp_valid & ~empty);
    assign clt_rsp_data  = rsp_data;
    assign clt_rsp_last  = rsp_last;
`endif

    assign err_unexp_d = err_unexp_q | (rsp_valid & rsp_ready & empty);
    assign err_ovf_d   = err_ovf_q | (req_accept & req_is_read & full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            err_unexp_q <= err_unexp_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign err_unexpected = err_unexp_q;
    assign err_overflow   = err_ovf_q;

endmodule

// File: tb/tb_mcif_rsp_router4.sv
// tb/tb_mcif_rsp_router4.sv - randomized scoreboard bench for mcif_rsp_router4 (either MCIF_RSP_OUT_REG_EN build)
module tb_mcif_rsp_router4;

    localparam int DW    = 256;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk, rst_n;
    logic          req_accept, req_is_read;
    logic [1:0]    req_client_id;
    logic          req_allow;
    logic          rsp_valid, rsp_last, rsp_ready;
    logic [DW-1:0] rsp_data, clt_rsp_data;
    logic [3:0]    clt_rsp_valid, clt_rsp_ready;
    logic          clt_rsp_last;
    logic [CW-1:0] outstanding;
    logic          err_unexpected, err_overflow;

    mcif_rsp_router4 #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_accept     (req_accept),
        .req_is_read    (req_is_read),
        .req_client_id  (req_client_id),
        .req_allow      (req_allow),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_last       (rsp_last),
        .rsp_ready      (rsp_ready),
        .clt_rsp_valid  (clt_rsp_valid),
        .clt_rsp_data   (clt_rsp_data),
        .clt_rsp_last   (clt_rsp_last),
        .clt_rsp_ready  (clt_rsp_ready),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
        .err_overflow   (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: queue of outstanding client IDs and queue of beats each client should receive.
    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    int    id_q[$];
    beat_t sb[$];
    bit    exp_ovf, exp_unexp;
    bit    mon_en;
    time   first_v_t;
    beat_t mb;

    int         rdy_mode;
    logic [3:0] rdy_fixed;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       clt_rsp_ready = 4'($urandom());
            2:       clt_rsp_ready = rdy_fixed;
            3:       clt_rsp_ready = ~clt_rsp_ready;
            default: clt_rsp_ready = 4'hF;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (|clt_rsp_valid && first_v_t == 0) first_v_t = $time;
            if (|clt_rsp_valid) chk("valid_onehot", ($countones(clt_rsp_valid) == 1), 1);
            if (|(clt_rsp_valid & clt_rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", clt_rsp_valid, 0);
                end else begin
                    mb = sb.pop_front();
                    chk("beat_client", clt_rsp_valid, 4'b1 << mb.id);
                    chk("beat_data", clt_rsp_data, mb.d);
                    chk("beat_last", clt_rsp_last, mb.l);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check_state(input string t);
        chk({t, "_outstanding"}, outstanding, id_q.size());
        chk({t, "_req_allow"}, req_allow, (id_q.size() < DEPTH));
        chk({t, "_err_overflow"}, err_overflow, exp_ovf);
        chk({t, "_err_unexpected"}, err_unexpected, exp_unexp);
    endtask

    task automatic push_req(input logic [1:0] id, input bit rd);
        req_accept    = 1'b1;
        req_is_read   = rd;
        req_client_id = id;
        @(posedge clk); #1;
        req_accept  = 1'b0;
        req_is_read = 1'b0;
        if (rd) begin
            if (id_q.size() < DEPTH) id_q.push_back(id);
            else exp_ovf = 1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit l);
        beat_t b;
        bit    got;
        rsp_valid = 1'b1;
        rsp_data  = d;
        rsp_last  = l;
        if (id_q.size() != 0) begin
            b.id = 2'(id_q[0]); b.d = d; b.l = l;
            sb.push_back(b);
        end
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
`ifndef MCIF_RSP_OUT_REG_EN
            if (id_q.size() != 0) chk("route_valid", clt_rsp_valid, 4'b1 << id_q[0]);
`endif
            got = rsp_ready;
        end
        if (!got) chk("rsp_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (id_q.size() == 0) exp_unexp = 1;
        else if (l) void'(id_q.pop_front());
        rsp_valid = 1'b0;
    endtask

    task automatic send_burst(input int len);
        for (int i = 0; i < len; i++) send_beat(rnd_data(), (i == len - 1));
    endtask

    initial begin
        rst_n = 0; req_accept = 0; req_is_read = 0; req_client_id = 0;
        rsp_valid = 0; rsp_data = '0; rsp_last = 0; clt_rsp_ready = 4'hF;
        rdy_mode = 0; rdy_fixed = 4'hF; exp_ovf = 0; exp_unexp = 0; mon_en = 1; first_v_t = 0;

        repeat (2) @(negedge clk);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_clt_valid", clt_rsp_valid, 0);
        check_state("rst");
        rst_n = 1;
        @(posedge clk); #1;

        // Reads for 2,0,3 then bursts of 4,1,2 beats.
        push_req(2, 1); push_req(0, 1); push_req(3, 1);
        check_state("t1_push");
        send_burst(4); check_state("t1_b0");
        send_burst(1); check_state("t1_b1");
        send_burst(2); check_state("t1_b2");

`ifndef MCIF_RSP_OUT_REG_EN
        // Head client 1 stalled while client 0 is ready: beat must be held.
        push_req(1, 1);
        rdy_mode = 2; rdy_fixed = 4'b0001;
        @(posedge clk); #1;
        rsp_valid = 1; rsp_last = 1; rsp_data = rnd_data();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_ready", rsp_ready, 0);
            chk("stall_clt_valid", clt_rsp_valid, 4'b0010);
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        send_beat(rsp_data, 1);
        check_state("t2");
`endif

        // Fill to DEPTH, overflow, then free one slot.
        rdy_mode = 1;
        for (int i = 0; i < DEPTH; i++) push_req(2'($urandom()), 1);
        check_state("t3_full");
        push_req(2'($urandom()), 1);
        check_state("t3_ovf");
        send_burst(1 + $urandom_range(0, 3));
        check_state("t3_free");

        for (int it = 0; it < 40; it++) begin
            if (id_q.size() == 0 || $urandom_range(0, 2) == 0) push_req(2'($urandom()), bit'($urandom()));
            else send_burst($urandom_range(1, 4));
            check_state("t3_rand");
        end
        while (id_q.size() != 0) send_burst($urandom_range(1, 3));
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check_state("t3_drain");

        // Stray beat with nothing outstanding.
        rsp_valid = 1; rsp_last = 1; rsp_data = rnd_data();
        @(negedge clk);
        chk("unexp_rsp_ready", rsp_ready, 1);
        chk("unexp_clt_valid", clt_rsp_valid, 0);
        @(posedge clk); #1;
        rsp_valid = 0; exp_unexp = 1;
        check_state("t4_unexp");
        push_req(2, 1);
        send_burst(2);
        check_state("t4_after");

        // Concurrent push of client 3 and pop of client 1's last beat at count 5.
        push_req(1, 1);
        for (int i = 0; i < 4; i++) push_req(2'($urandom()), 1);
        check_state("t5_pre");
        rsp_valid = 1; rsp_last = 1; rsp_data = rnd_data();
        sb.push_back('{id: 2'd1, d: rsp_data, l: 1'b1});
        req_accept = 1; req_is_read = 1; req_client_id = 3;
        @(negedge clk);
        chk("t5_rsp_ready", rsp_ready, 1);
        @(posedge clk); #1;
        rsp_valid = 0; req_accept = 0; req_is_read = 0;
        void'(id_q.pop_front());
        id_q.push_back(3);
        check_state("t5_same");
        while (id_q.size() != 0) send_burst($urandom_range(1, 2));
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

`ifdef MCIF_RSP_OUT_REG_EN
        // 8-beat back-to-back burst with toggling ready; first beat one cycle late.
        push_req(2'($urandom()), 1);
        rdy_mode = 3;
        first_v_t = 0;
        chk("skid_lat_start", clt_rsp_valid, 0);
        begin
            time t0;
            t0 = $time;
            send_burst(8);
            repeat (6) @(posedge clk);
            #1;
            chk("skid_latency", first_v_t - t0, 14);
        end
        chk("skid_drained", sb.size(), 0);
        check_state("skid_done");

        // Async reset mid-burst clears everything at once.
        rdy_mode = 0; mon_en = 0;
        push_req(2'($urandom()), 1);
        rsp_valid = 1; rsp_last = 0; rsp_data = rnd_data();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("mrst_clt_valid", clt_rsp_valid, 0);
        chk("mrst_clt_data", clt_rsp_data, 0);
        chk("mrst_clt_last", clt_rsp_last, 0);
        chk("mrst_rsp_ready", rsp_ready, 0);
        id_q.delete(); sb.delete(); exp_ovf = 0; exp_unexp = 0;
        check_state("mrst");
        rsp_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
